// File: rtl/vga_stream_sequencer.sv
// vga_stream_sequencer: wraps raw pixels into Avalon-ST video control + data packets per frame
module vga_stream_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DATA_W   = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_startofpacket,
  output logic              m_endofpacket,
  output logic [1:0]        m_empty,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              frame_done
);
  typedef enum logic [2:0] {IDLE, CTRL_HDR, CTRL_BODY, VID_HDR, VID_BODY} state_t;
  localparam logic [15:0] W  = 16'(H_ACTIVE);
  localparam logic [15:0] H  = 16'(V_ACTIVE);
  localparam logic [29:0] C0 = {6'd0, W[7:4], 6'd0, W[11:8], 6'd0, W[15:12]};
  localparam logic [29:0] C1 = {6'd0, H[11:8], 6'd0, H[15:12], 6'd0, W[3:0]};
  localparam logic [29:0] C2 = {6'd0, 4'h3, 6'd0, H[3:0], 6'd0, H[7:4]};
  state_t      r_state, w_next;
  logic [15:0] r_x, r_y;
  logic [1:0]  r_b;
  logic        r_frame_done;
  logic        w_last_x, w_last_y, w_xfer;
  assign w_last_x   = r_x == 16'(H_ACTIVE - 1);
  assign w_last_y   = r_y == 16'(V_ACTIVE - 1);
  assign w_xfer     = m_valid && m_ready;
  assign m_empty    = 2'd0;
  assign busy       = r_state != IDLE;
  assign frame_done = r_frame_done;
  // Beat selection and next state; header beats come from state, pixel beats pass straight through
  always_comb begin
    w_next          = r_state;
    m_valid         = 1'b0;
    s_ready         = 1'b0;
    m_data          = '0;
    m_startofpacket = 1'b0;
    m_endofpacket   = 1'b0;
    case (r_state)
      IDLE: w_next = enable ? CTRL_HDR : IDLE;
      CTRL_HDR: begin
        m_valid         = 1'b1;
        m_startofpacket = 1'b1;
        m_data          = DATA_W'(30'hF);
        w_next          = m_ready ? CTRL_BODY : CTRL_HDR;
      end
      CTRL_BODY: begin
        m_valid       = 1'b1;
        m_data        = DATA_W'(r_b == 2'd0 ? C0 : r_b == 2'd1 ? C1 : C2);
        m_endofpacket = r_b == 2'd2;
        w_next        = (m_ready && r_b == 2'd2) ? VID_HDR : CTRL_BODY;
      end
      VID_HDR: begin
        m_valid         = 1'b1;
        m_startofpacket = 1'b1;
        w_next          = m_ready ? VID_BODY : VID_HDR;
      end
      VID_BODY: begin
        m_valid       = s_valid;
        s_ready       = m_ready;
        m_data        = s_data;
        m_endofpacket = w_last_x && w_last_y;
        w_next        = (w_xfer && w_last_x && w_last_y) ? (enable ? CTRL_HDR : IDLE) : VID_BODY;
      end
      default: w_next = IDLE;
    endcase
  end
  // State, beat/pixel counters and the end-of-frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_b          <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_frame_done <= r_state == VID_BODY && w_xfer && w_last_x && w_last_y;
      if (r_state == CTRL_HDR) r_b <= '0;
      if (r_state == CTRL_BODY && w_xfer) r_b <= r_b + 2'd1;
      if (r_state == VID_HDR) begin
        r_x <= '0;
        r_y <= '0;
      end
      if (r_state == VID_BODY && w_xfer) begin
        r_x <= w_last_x ? '0 : r_x + 16'd1;
        r_y <= w_last_x ? (w_last_y ? '0 : r_y + 16'd1) : r_y;
      end
    end
  end
endmodule

// File: tb/tb_vga_stream_sequencer.sv
// tb_vga_stream_sequencer: scoreboard bench for the video packet sequencer
module tb_vga_stream_sequencer;
  localparam int HA = 4;
  localparam int VA = 2;
  localparam int DW = 30;
  logic clk = 0, rst = 1, enable = 0, s_valid = 0, m_ready = 1;
  logic s_ready, m_startofpacket, m_endofpacket, m_valid, busy, frame_done;
  logic [DW-1:0] s_data = '0, m_data;
  logic [1:0] m_empty;
  vga_stream_sequencer #(.H_ACTIVE(HA), .V_ACTIVE(VA), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .m_data(m_data), .m_startofpacket(m_startofpacket),
    .m_endofpacket(m_endofpacket), .m_empty(m_empty), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .frame_done(frame_done));
  always #5 clk = ~clk;
  typedef struct packed {logic [DW-1:0] d; logic s; logic e; logic f;} beat_t;
  beat_t q[$];
  int checks = 0, errors = 0, pix = 1, exp_pix = 1, stall_at = -1, stall_left = 0;
  bit rr = 0, vr = 0, stalling = 0, hs = 0, exp_fd = 0, pend = 0, exp_hdr = 0;
  logic [DW+1:0] held;
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic logic [29:0] sym(int a, int b, int c);
    return {6'd0, 4'(a), 6'd0, 4'(b), 6'd0, 4'(c)};
  endfunction
  // Reference: one frame is a 4-beat control packet then header + HA*VA sequential pixels
  task automatic push_frame();
    q.push_back(beat_t'{DW'(30'hF), 1'b1, 1'b0, 1'b0});
    q.push_back(beat_t'{DW'(sym(HA >> 4, HA >> 8, HA >> 12)), 1'b0, 1'b0, 1'b0});
    q.push_back(beat_t'{DW'(sym(VA >> 8, VA >> 12, HA)), 1'b0, 1'b0, 1'b0});
    q.push_back(beat_t'{DW'(sym(3, VA, VA >> 4)), 1'b0, 1'b1, 1'b0});
    q.push_back(beat_t'{DW'(0), 1'b1, 1'b0, 1'b0});
    for (int k = 0; k < HA * VA; k++) begin
      q.push_back(beat_t'{DW'(exp_pix), 1'b0, k == HA * VA - 1, k == HA * VA - 1});
      exp_pix++;
    end
  endtask
  // Monitor: pops the scoreboard on every transfer and checks stall stability and frame_done
  always @(negedge clk) begin
    if (rst) begin
      exp_fd = 0;
      pend = 0;
      exp_hdr = 0;
    end else begin
      chk("frame_done", frame_done, exp_fd);
      chk("m_empty", m_empty, 0);
      exp_fd = 0;
      if (pend) chk("stall_hold", {m_valid, m_data, m_startofpacket, m_endofpacket}, {1'b1, held});
      if (exp_hdr) chk("b2b_hdr", {m_valid, m_startofpacket, m_data}, {2'b11, DW'(30'hF)});
      exp_hdr = 0;
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got data %0h sop %0b eop %0b with nothing expected", m_data, m_startofpacket, m_endofpacket);
        end else begin
          beat_t b;
          b = q.pop_front();
          chk("beat", {m_data, m_startofpacket, m_endofpacket}, {b.d, b.s, b.e});
          if (b.f) begin
            exp_fd = 1;
            exp_hdr = q.size() > 0;
          end
        end
      end
      pend = m_valid && !m_ready;
      held = {m_data, m_startofpacket, m_endofpacket};
    end
  end
  // One clock of source/sink stimulus: sequential pixels, held until accepted
  task automatic step();
    @(negedge clk);
    hs = s_valid && s_ready;
    if (stalling) chk("stall_mvalid", m_valid, 0);
    @(posedge clk);
    #1;
    if (hs) pix++;
    s_data = DW'(pix);
    m_ready = rr ? 1'($urandom % 2) : 1'b1;
    if (hs && pix == stall_at) stall_left = 5;
    stalling = stall_left > 0;
    if (stalling) begin
      s_valid = 0;
      stall_left--;
    end else if (!(s_valid && !hs)) s_valid = vr ? 1'($urandom % 2) : 1'b1;
  endtask
  task automatic run(int n, bit r_rdy, bit r_val);
    int t;
    t = 0;
    rr = r_rdy;
    vr = r_val;
    for (int i = 0; i < n; i++) push_frame();
    enable = 1;
    while (q.size() > 0 && t < 3000) begin
      step();
      t++;
      if (q.size() <= 6) enable = 0;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d beats still expected after %0d cycles", q.size(), t);
      q.delete();
    end
    repeat (6) step();
    chk("idle_busy", busy, 0);
    chk("idle_mvalid", m_valid, 0);
  endtask
  initial begin
    int t;
    rst = 1;
    step();
    step();
    chk("rst_mvalid", m_valid, 0);
    chk("rst_sready", s_ready, 0);
    chk("rst_sop_eop", {m_startofpacket, m_endofpacket}, 0);
    chk("rst_mdata", m_data, 0);
    chk("rst_busy_fd", {busy, frame_done, m_empty}, 0);
    rst = 0;
    run(1, 0, 0);
    run(1, 1, 0);
    stall_at = exp_pix + 3;
    run(1, 0, 0);
    stall_at = -1;
    run(3, 1, 1);
    rr = 0;
    vr = 0;
    push_frame();
    enable = 1;
    t = 0;
    while (q.size() > 5 && t < 200) begin
      step();
      t++;
    end
    chk("reach_vid_body", q.size() <= 5, 1);
    rst = 1;
    step();
    rst = 0;
    enable = 0;
    q.delete();
    exp_pix = pix;
    @(negedge clk);
    chk("midrst_mvalid", m_valid, 0);
    chk("midrst_sready", s_ready, 0);
    chk("midrst_busy", busy, 0);
    run(1, 1, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
